// File: rtl/life_scheduler_if.sv
// life_scheduler_if: frame/datapath handshake and board write-port control
// bundle for life_scheduler.
//   master : the scheduler side (takes vsync/run/step/clear/done, drives
//            start, bank select, clear write port, generation count, busy)
//   slave  : the surrounding datapath/display/control side
// ADDR_W must equal LOG_MAX_ADDR+1 of the scheduler; the MSB of
// clr_addr_out selects the bank.
interface life_scheduler_if #(
    parameter int ADDR_W = 4,
    parameter int GEN_W  = 16
);
    logic              vsync_in;
    logic              run_in;
    logic              step_in;
    logic              clear_in;
    logic              logic_done_in;
    logic              logic_start_out;
    logic              buf_sel_out;
    logic              wr_sel_out;
    logic              clr_wr_en_out;
    logic [ADDR_W-1:0] clr_addr_out;
    logic [GEN_W-1:0]  gen_count_out;
    logic              busy_out;

    modport master (
        input  vsync_in, run_in, step_in, clear_in, logic_done_in,
        output logic_start_out, buf_sel_out, wr_sel_out, clr_wr_en_out,
               clr_addr_out, gen_count_out, busy_out
    );

    modport slave (
        output vsync_in, run_in, step_in, clear_in, logic_done_in,
        input  logic_start_out, buf_sel_out, wr_sel_out, clr_wr_en_out,
               clr_addr_out, gen_count_out, busy_out
    );
endinterface

// File: rtl/life_scheduler.sv
// life_scheduler: generation sequencer and board write-port arbiter.
// Starts one life_logic generation per frame (run), per step request
// (paused), waits for done past a guard window, then flips the display
// bank on vsync. Optional clear engine zeroes both banks.
//
// Build option: define LIFE_SCHED_CLEAR_EN to include the clear engine;
// without it clear_in is ignored and the clear write port is tied off.
//
// Ports:
//   clk_in    system clock
//   rst_n_in  synchronous active-low reset
//   bus       life_scheduler_if.master (vsync/run/step/clear/done in;
//             start, buf_sel, wr_sel, clr_wr_en, clr_addr, gen_count, busy out)
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for vsync with run or a pending step, or a clear
// START     | one-cycle start pulse to life_logic, guard restarts
// COMPUTE   | datapath busy; done honoured once guard reaches DONE_GUARD
// WAIT_SWAP | generation ready; flip bank on the next vsync
// CLEAR     | clear engine owns the write port, one zero word per cycle
module life_scheduler #(
    parameter int LOG_MAX_ADDR = 3,
    parameter int WORDS        = 2 ** LOG_MAX_ADDR,
    parameter int DONE_GUARD   = 4,
    parameter int GEN_W        = 16
) (
    input logic              clk_in,
    input logic              rst_n_in,
    life_scheduler_if.master bus
);
    localparam int ADDR_W  = LOG_MAX_ADDR + 1;
    localparam int GUARD_W = $clog2(DONE_GUARD + 2);
    localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(DONE_GUARD);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_COMPUTE   = 3'd2;
    localparam logic [2:0] S_WAIT_SWAP = 3'd3;
    localparam logic [2:0] S_CLEAR     = 3'd4;

    // Both banks must fit in the clear address space.
    if (WORDS < 1 || 2 * WORDS > 2 ** ADDR_W) begin : g_bad_words
        $error("WORDS does not fit in clr_addr_out");
    end

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [GUARD_W-1:0] guard;
    logic               step_pend;
    logic               logic_start;
    logic               buf_sel;
    logic [GEN_W-1:0]   gen_count;
    logic               busy;
    logic               clr_go_idle;
    logic               clr_go_swap;
    logic               clr_last;

`ifdef LIFE_SCHED_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 * WORDS - 1);

    logic              clr_pend;
    logic              clr_wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] clr_addr;

    // A clear request seen in IDLE wins over a simultaneous vsync.
    assign clr_go_idle = clr_pend | bus.clear_in;
    assign clr_go_swap = clr_pend;
    assign clr_last    = (clr_addr == LAST_ADDR);

    assign bus.wr_sel_out    = wr_sel;
    assign bus.clr_wr_en_out = clr_wr_en;
    assign bus.clr_addr_out  = clr_addr;
`else
    assign clr_go_idle = 1'b0;
    assign clr_go_swap = 1'b0;
    assign clr_last    = 1'b1;

    assign bus.wr_sel_out    = 1'b0;
    assign bus.clr_wr_en_out = 1'b0;
    assign bus.clr_addr_out  = '0;
`endif

    assign bus.logic_start_out = logic_start;
    assign bus.buf_sel_out     = buf_sel;
    assign bus.gen_count_out   = gen_count;
    assign bus.busy_out        = busy;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clr_go_idle)
                    state_nxt = S_CLEAR;
                else if (bus.vsync_in && (bus.run_in || step_pend))
                    state_nxt = S_START;
            end
            S_START:   state_nxt = S_COMPUTE;
            S_COMPUTE: begin
                if (guard == GUARD_MAX && bus.logic_done_in)
                    state_nxt = S_WAIT_SWAP;
            end
            S_WAIT_SWAP: begin
                // Chaining straight into START keeps free-run at one
                // generation per frame.
                if (bus.vsync_in) begin
                    if (clr_go_swap)      state_nxt = S_CLEAR;
                    else if (bus.run_in)  state_nxt = S_START;
                    else                  state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (clr_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state       <= S_IDLE;
            guard       <= '0;
            step_pend   <= 1'b0;
            logic_start <= 1'b0;
            buf_sel     <= 1'b0;
            gen_count   <= '0;
            busy        <= 1'b0;
`ifdef LIFE_SCHED_CLEAR_EN
            clr_pend    <= 1'b0;
            clr_wr_en   <= 1'b0;
            wr_sel      <= 1'b0;
            clr_addr    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != S_IDLE);
            logic_start <= (state_nxt == S_START);

            if (state == S_START)
                guard <= '0;
            else if (state == S_COMPUTE && guard != GUARD_MAX)
                guard <= guard + 1'b1;

            // START is never re-entered from itself, so next==START is an entry.
            if (state_nxt == S_START)
                step_pend <= 1'b0;
            else if (bus.step_in && !bus.run_in)
                step_pend <= 1'b1;

            if (state == S_WAIT_SWAP && bus.vsync_in) begin
                buf_sel   <= ~buf_sel;
                gen_count <= gen_count + 1'b1;
            end

`ifdef LIFE_SCHED_CLEAR_EN
            if (state_nxt == S_CLEAR && state != S_CLEAR)
                clr_pend <= 1'b0;
            else if (bus.clear_in)
                clr_pend <= 1'b1;

            if (state_nxt == S_CLEAR && state != S_CLEAR) begin
                wr_sel    <= 1'b1;
                clr_wr_en <= 1'b1;
                clr_addr  <= '0;
            end else if (state == S_CLEAR) begin
                if (clr_last) begin
                    wr_sel    <= 1'b0;
                    clr_wr_en <= 1'b0;
                    clr_addr  <= '0;
                    gen_count <= '0;
                    step_pend <= 1'b0;
                end else begin
                    clr_addr <= clr_addr + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_life_scheduler.sv
module tb_life_scheduler;
    localparam int LOG_MAX_ADDR = 3;
    localparam int WORDS        = 8;
    localparam int DONE_GUARD   = 4;
    localparam int GEN_W        = 16;

`ifdef LIFE_SCHED_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_START = 1, M_COMPUTE = 2, M_WAIT = 3, M_CLEAR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    life_scheduler_if #(.ADDR_W(LOG_MAX_ADDR + 1), .GEN_W(GEN_W)) bus ();

    life_scheduler #(
        .LOG_MAX_ADDR(LOG_MAX_ADDR),
        .WORDS(WORDS),
        .DONE_GUARD(DONE_GUARD),
        .GEN_W(GEN_W)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // reference model: what the outputs must be after each edge
    int          m_mode = M_IDLE;
    int          m_start_edge = 0;
    int          m_clear_edge = 0;
    logic        m_start = 0, m_buf = 0, m_en = 0, m_busy = 0;
    logic        m_step_pend = 0, m_clr_pend = 0;
    logic [3:0]  m_addr = 0;
    logic [15:0] m_gen = 0;

    // stimulus helpers
    int dp_cnt = 0, lat = 40, stale = 0;
    bit rnd_lat = 0, rnd_per = 0, vs_en = 0;
    int vper = 100, vcnt = 0;
    int start_cnt = 0, wr_cnt = 0, busy_cnt = 0;
    int swap_edge = 0, first_en_edge = 0;
    logic prev_buf = 0;

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {7'd0, bus.logic_start_out, bus.buf_sel_out, bus.wr_sel_out, bus.clr_wr_en_out,
                bus.clr_addr_out, bus.gen_count_out, bus.busy_out};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {7'd0, m_start, m_buf, m_en, m_en, m_addr, m_gen, m_busy};
    endfunction

    // Advances the behavioural model by one clock edge using the inputs
    // that the DUT sampled at that edge.
    task automatic model_step();
        int nm;
        if (!rst_n) begin
            m_mode = M_IDLE; m_start = 0; m_buf = 0; m_en = 0; m_busy = 0;
            m_step_pend = 0; m_clr_pend = 0; m_addr = 0; m_gen = 0;
            return;
        end
        nm = m_mode;
        case (m_mode)
            M_IDLE: begin
                if (CLR_EN && (m_clr_pend || bus.clear_in)) nm = M_CLEAR;
                else if (bus.vsync_in && (bus.run_in || m_step_pend)) nm = M_START;
            end
            M_START: nm = M_COMPUTE;
            M_COMPUTE: begin
                // done counts only from DONE_GUARD+1 cycles after the start pulse
                if (bus.logic_done_in && (edge_n - m_start_edge) >= DONE_GUARD + 2) nm = M_WAIT;
            end
            M_WAIT: begin
                if (bus.vsync_in) begin
                    m_buf = !m_buf;
                    m_gen = m_gen + 16'd1;
                    if (CLR_EN && m_clr_pend) nm = M_CLEAR;
                    else if (bus.run_in)      nm = M_START;
                    else                      nm = M_IDLE;
                end
            end
            default: ;
        endcase

        if (nm == M_START) m_step_pend = 0;
        else if (bus.step_in && !bus.run_in) m_step_pend = 1;
        if (nm == M_CLEAR && m_mode != M_CLEAR) m_clr_pend = 0;
        else if (CLR_EN && bus.clear_in) m_clr_pend = 1;
        if (nm == M_START) m_start_edge = edge_n;

        if (nm == M_CLEAR && m_mode != M_CLEAR) begin
            m_clear_edge = edge_n;
            m_addr = 0;
            m_en = 1;
        end else if (m_mode == M_CLEAR) begin
            if (edge_n - m_clear_edge == 2 * WORDS) begin
                nm = M_IDLE; m_en = 0; m_addr = 0; m_gen = 0; m_step_pend = 0;
            end else begin
                m_addr = 4'(edge_n - m_clear_edge);
            end
        end
        m_mode  = nm;
        m_start = (nm == M_START);
        m_busy  = (nm != M_IDLE);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        model_step();
        chk("cycle", dut_vec(), exp_vec());

        if (bus.logic_start_out) begin
            start_cnt++;
            dp_cnt = 0;
            if (rnd_lat) begin
                lat = $urandom_range(2, 60);
                stale = $urandom_range(0, 3);
            end
        end else if (dp_cnt < 100000) begin
            dp_cnt++;
        end
        if (bus.clr_wr_en_out) begin
            wr_cnt++;
            if (first_en_edge == 0) first_en_edge = edge_n;
        end
        if (bus.busy_out) busy_cnt++;
        if (bus.buf_sel_out != prev_buf) swap_edge = edge_n;
        prev_buf = bus.buf_sel_out;

        // datapath: optional stale done right after start, real done at lat, then held
        bus.logic_done_in = ((dp_cnt >= 1 && dp_cnt <= stale) || dp_cnt >= lat);
        bus.step_in  = 0;
        bus.clear_in = 0;
        if (vcnt + 1 >= vper) begin
            vcnt = 0;
            if (rnd_per) vper = $urandom_range(20, 80);
        end else begin
            vcnt++;
        end
        bus.vsync_in = vs_en && (vcnt == 0);

        if (errors >= 50) summary_and_finish();
    endtask

    task automatic start_frames(input int per);
        vper  = per;
        vcnt  = per - 1;
        vs_en = 1;
    endtask

    task automatic wait_start(input string tag, input int limit);
        int n = 0;
        while (!bus.logic_start_out && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < limit), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.vsync_in = 0; bus.run_in = 0; bus.step_in = 0;
        bus.clear_in = 0; bus.logic_done_in = 0;

        // reset
        rst_n = 0;
        repeat (3) tick();
        chk("reset", dut_vec(), 32'd0);
        rst_n = 1;

        // free-run: vsync every 100, done 40 after start
        lat = 40; stale = 0; start_cnt = 0;
        bus.run_in = 1;
        start_frames(100);
        repeat (600) tick();
        chk("run_starts", 32'(start_cnt), 32'd6);
        chk("run_gen", 32'(bus.gen_count_out), 32'd5);
        chk("run_buf", 32'(bus.buf_sel_out), 32'd1);

        // dropping run lets the in-flight generation swap, then stops
        bus.run_in = 0;
        start_cnt = 0;
        repeat (200) tick();
        chk("run_stop_starts", 32'(start_cnt), 32'd1 - 32'd1);
        chk("run_stop_gen", 32'(bus.gen_count_out), 32'd6);

        // two step pulses between vsyncs -> one generation
        repeat (30) tick();
        start_cnt = 0;
        bus.step_in = 1; tick();
        repeat (5) tick();
        bus.step_in = 1; tick();
        repeat (300) tick();
        chk("step_starts", 32'(start_cnt), 32'd1);
        chk("step_gen", 32'(bus.gen_count_out), 32'd7);

        // stale done for 3 cycles after start must not reach WAIT_SWAP
        stale = 3; lat = 60;
        start_frames(20);
        bus.step_in = 1; tick();
        wait_start("stale_wait_start", 100);
        repeat (25) tick();
        chk("stale_noswap", 32'(bus.buf_sel_out), 32'd1);
        repeat (100) tick();
        chk("stale_gen", 32'(bus.gen_count_out), 32'd8);

        // clear during COMPUTE: swap first, then 16 writes, then gen 0
        stale = 0; lat = 40;
        start_frames(100);
        bus.step_in = 1; tick();
        wait_start("clr_wait_start", 150);
        repeat (10) tick();
        wr_cnt = 0; swap_edge = 0; first_en_edge = 0;
        bus.clear_in = 1; tick();
        repeat (250) tick();
        chk("clr_writes", 32'(wr_cnt), CLR_EN ? 32'd16 : 32'd0);
        chk("clr_gen", 32'(bus.gen_count_out), CLR_EN ? 32'd0 : 32'd9);
        chk("clr_buf", 32'(bus.buf_sel_out), 32'd1);
`ifdef LIFE_SCHED_CLEAR_EN
        chk("clr_swap_first", 32'(swap_edge != 0 && first_en_edge > swap_edge), 32'd1);

        // reset mid-clear at address 5 abandons the clear
        bus.clear_in = 1; tick();
        begin
            int n = 0;
            while (!(bus.clr_wr_en_out && bus.clr_addr_out == 4'd5) && n < 40) begin
                tick();
                n++;
            end
            chk("wait_addr5", 32'(n < 40), 32'd1);
        end
        rst_n = 0; tick();
        chk("rst_mid", dut_vec(), 32'd0);
        rst_n = 1;
        wr_cnt = 0;
        repeat (20) tick();
        chk("rst_no_writes", 32'(wr_cnt), 32'd0);
`else
        // clear_in ignored without the clear engine
        wr_cnt = 0; busy_cnt = 0;
        bus.clear_in = 1; tick();
        repeat (20) tick();
        chk("noclr_writes", 32'(wr_cnt), 32'd0);
        chk("noclr_busy", 32'(busy_cnt), 32'd0);
`endif

        // randomized traffic against the model
        rnd_lat = 1; rnd_per = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) bus.run_in = !bus.run_in;
            if ($urandom_range(0, 39) == 0)  bus.step_in = 1;
            if ($urandom_range(0, 499) == 0) bus.clear_in = 1;
            rst_n = ($urandom_range(0, 1999) != 0);
            tick();
        end
        rst_n = 1;
        tick();

        summary_and_finish();
    end
endmodule
